// File: rtl/test_monitor.sv
// ---------------------------------------------------------------------------
// test_monitor
//
// End-of-test monitor for the CPU core / dual_port_ram harness. It watches
// the instruction fetch address and the data-store bus. Once it decides pass
// or fail it latches the verdict until the next reset.
//
// Verdict sources, highest priority first:
//   fail address > fail mailbox store > pass address > pass mailbox store
//   > PC stall > global timeout
//
// Ports
//   clk         : single clock, rising edge
//   rst         : synchronous, active-high reset
//   iaddr       : core instruction fetch address
//   addr        : core data address
//   wdata       : core store data
//   wr          : core store strobe
//   done        : verdict latched
//   pass        : verdict is pass (meaningful only while done)
//   status      : 0 run, 1 pass-addr, 2 pass-tohost, 3 fail-addr,
//                 4 fail-tohost, 5 timeout, 6 stall
//   fail_code   : wdata >> 1 of a failing mailbox store, otherwise 0
//   cycle_count : RUN cycles elapsed, saturating, frozen at the verdict
// ---------------------------------------------------------------------------
module test_monitor #(
   parameter int                ADDR_W         = 32,
   parameter logic [ADDR_W-1:0] PASS_ADDR      = 'h698,
   parameter logic [ADDR_W-1:0] FAIL_ADDR      = 'h684,
   parameter bit                TOHOST_EN      = 1'b1,
   parameter logic [ADDR_W-1:0] TOHOST_ADDR    = 'h1000,
   parameter int                START_DELAY    = 2,
   parameter int                TIMEOUT_CYCLES = 1200,
   parameter int                STALL_CYCLES   = 16,
   parameter int                CNT_W          = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] iaddr,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   input  logic              wr,
   output logic              done,
   output logic              pass,
   output logic [2:0]        status,
   output logic [31:0]       fail_code,
   output logic [CNT_W-1:0]  cycle_count
);

   localparam logic [2:0] ST_RUNNING  = 3'd0;
   localparam logic [2:0] ST_PASS_ADR = 3'd1;
   localparam logic [2:0] ST_PASS_TH  = 3'd2;
   localparam logic [2:0] ST_FAIL_ADR = 3'd3;
   localparam logic [2:0] ST_FAIL_TH  = 3'd4;
   localparam logic [2:0] ST_TIMEOUT  = 3'd5;
   localparam logic [2:0] ST_STALL    = 3'd6;

   localparam int WAIT_W  = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
   localparam int STALL_W = (STALL_CYCLES > 0) ? $clog2(STALL_CYCLES + 1) : 1;

   localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(START_DELAY - 1);
   localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_CYCLES);
   localparam logic [CNT_W-1:0]   TO_MATCH  = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_WAIT = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // With no start delay the monitor is live from the first edge after reset.
   localparam state_t RST_STATE = (START_DELAY == 0) ? S_RUN : S_WAIT;

   state_t               state, state_nx;
   logic [WAIT_W-1:0]    wait_cnt;
   logic [ADDR_W-1:0]    prev_iaddr;
   logic                 prev_valid;
   logic [STALL_W-1:0]   stall_cnt, stall_nx;
   logic [2:0]           verdict;
   logic                 ev_fa, ev_ft, ev_pa, ev_pt, ev_st, ev_to, ev_store;

   // Event decode from the current input sample.
   always_comb begin
      ev_store = TOHOST_EN && wr && (addr == TOHOST_ADDR);
      ev_fa    = (iaddr == FAIL_ADDR);
      ev_pa    = (iaddr == PASS_ADDR);
      ev_ft    = ev_store && (wdata != 32'd1);
      ev_pt    = ev_store && (wdata == 32'd1);

      // The first RUN cycle has no valid previous sample, so it always clears.
      stall_nx = '0;
      if (prev_valid && (iaddr == prev_iaddr)) begin
         stall_nx = (stall_cnt == STALL_MAX) ? stall_cnt : stall_cnt + STALL_W'(1);
      end
      // Stall fires on the cycle whose update brings the counter to the limit.
      ev_st = (STALL_CYCLES != 0) && (stall_nx == STALL_MAX);
      ev_to = (TIMEOUT_CYCLES != 0) && (cycle_count == TO_MATCH);
   end

   // Next state and priority-resolved verdict.
   always_comb begin
      state_nx = state;
      verdict  = ST_RUNNING;
      case (state)
         S_WAIT: begin
            if (wait_cnt == WAIT_LAST) state_nx = S_RUN;
         end
         S_RUN: begin
            if      (ev_fa) verdict = ST_FAIL_ADR;
            else if (ev_ft) verdict = ST_FAIL_TH;
            else if (ev_pa) verdict = ST_PASS_ADR;
            else if (ev_pt) verdict = ST_PASS_TH;
            else if (ev_st) verdict = ST_STALL;
            else if (ev_to) verdict = ST_TIMEOUT;
            if (verdict != ST_RUNNING) state_nx = S_DONE;
         end
         S_DONE: begin
            state_nx = S_DONE;
         end
         default: begin
            state_nx = RST_STATE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= RST_STATE;
         wait_cnt    <= '0;
         prev_iaddr  <= '0;
         prev_valid  <= 1'b0;
         stall_cnt   <= '0;
         done        <= 1'b0;
         pass        <= 1'b0;
         status      <= ST_RUNNING;
         fail_code   <= '0;
         cycle_count <= '0;
      end else begin
         state <= state_nx;
         if (state == S_WAIT) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
         end
         if (state == S_RUN) begin
            prev_iaddr <= iaddr;
            prev_valid <= 1'b1;
            stall_cnt  <= stall_nx;
            // Saturate instead of wrapping so a long run never looks fresh.
            if (cycle_count != '1) cycle_count <= cycle_count + CNT_W'(1);
            if (verdict != ST_RUNNING) begin
               done      <= 1'b1;
               status    <= verdict;
               pass      <= (verdict == ST_PASS_ADR) || (verdict == ST_PASS_TH);
               fail_code <= (verdict == ST_FAIL_TH) ? {1'b0, wdata[31:1]} : 32'd0;
            end
         end
      end
   end

endmodule
